// File: rtl/plic_target_arbiter_pkg.sv
// Shared types and helpers for the PLIC target arbiter.
// The best-candidate struct is sized from the package defaults. Modules that
// use it are meant to be built with those same N_SRC/PRIO_W values.
package plic_pkg;

  // ID width that holds 0 ("no interrupt") plus IDs 1..n.
  function automatic int id_w(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int NO_IRQ_ID   = 0;
  localparam int PLIC_N_SRC  = 31;
  localparam int PLIC_PRIO_W = 3;
  localparam int PLIC_ID_W   = id_w(PLIC_N_SRC);

  typedef struct packed {
    logic [PLIC_ID_W-1:0]   id;
    logic [PLIC_PRIO_W-1:0] prio;
    logic                   valid;
  } plic_best_t;

endpackage

// File: rtl/plic_target_arbiter_if.sv
// Gateway handshake, config-write and claim/complete bundle for one hart context.
// The slave modport is the PLIC side. The master modport is the gateway/hart side.
interface plic_target_arbiter_if import plic_pkg::*; #(
  parameter int N_SRC  = PLIC_N_SRC,
  parameter int PRIO_W = PLIC_PRIO_W
) ();
  localparam int ID_W = id_w(N_SRC);

  logic [N_SRC-1:0]  gw_valid;
  logic [N_SRC-1:0]  gw_ready;
  logic [N_SRC-1:0]  gw_complete;
  logic              prio_wen;
  logic [ID_W-1:0]   prio_idx;
  logic [PRIO_W-1:0] prio_wdata;
  logic              en_wen;
  logic [N_SRC-1:0]  en_wdata;
  logic              thr_wen;
  logic [PRIO_W-1:0] thr_wdata;
  logic              claim_req;
  logic [ID_W-1:0]   claim_id;
  logic              complete_valid;
  logic [ID_W-1:0]   complete_id;
  logic              eip;
  logic [N_SRC-1:0]  pending_o;

  modport slave (
    input  gw_valid, prio_wen, prio_idx, prio_wdata, en_wen, en_wdata,
           thr_wen, thr_wdata, claim_req, complete_valid, complete_id,
    output gw_ready, gw_complete, claim_id, eip, pending_o
  );

  modport master (
    output gw_valid, prio_wen, prio_idx, prio_wdata, en_wen, en_wdata,
           thr_wen, thr_wdata, claim_req, complete_valid, complete_id,
    input  gw_ready, gw_complete, claim_id, eip, pending_o
  );
endinterface

// File: rtl/plic_target_arbiter_prio_tree.sv
// plic_prio_tree: log-depth max/argmax reduction over {eligible, prio, id}.
// Leaves are ordered by ascending ID and the left operand of each merge holds
// the lower IDs. Equal priorities therefore resolve to the lowest ID.
module plic_prio_tree import plic_pkg::*; #(
  parameter int N_SRC  = PLIC_N_SRC,
  parameter int PRIO_W = PLIC_PRIO_W
) (
  input  logic [N_SRC-1:0]             i_elig,
  input  logic [N_SRC-1:0][PRIO_W-1:0] i_prio,
  output plic_best_t                   o_best
);
  localparam int LVLS   = (N_SRC > 1) ? $clog2(N_SRC) : 0;
  localparam int LEAVES = 1 << LVLS;

  // Right side (higher IDs) wins only on a strictly greater priority.
  function automatic plic_best_t pick(input plic_best_t a, input plic_best_t b);
    if (b.valid && (!a.valid || (b.prio > a.prio))) return b;
    return a;
  endfunction

  // Pairwise reduction, in place. Level l folds LEAVES>>l nodes into half as many.
  always_comb begin : tree
    plic_best_t node [LEAVES];
    for (int i = 0; i < LEAVES; i++) node[i] = '0;
    for (int i = 0; i < N_SRC; i++) begin
      node[i].valid = i_elig[i];
      node[i].prio  = i_prio[i];
      node[i].id    = PLIC_ID_W'(i + 1);
    end
    for (int l = 0; l < LVLS; l++)
      for (int j = 0; j < (LEAVES >> (l + 1)); j++)
        node[j] = pick(node[2*j], node[2*j+1]);
    o_best = node[0];
  end
endmodule

// File: rtl/plic_target_arbiter.sv
// plic_target_arbiter: PLIC endpoint for one hart context.
// It latches gateway requests into pending bits and arbitrates the eligible
// sources by priority, with the lowest ID winning a tie. It drives eip against
// the threshold, serves claim/complete, and pulses gw_complete back to the
// originating gateway.
// Optional feature macro PLIC_ARB_PIPE_EN registers the arbitration result
// (best_q). This adds one cycle of eip/claim_id latency. A stale flag blocks
// claims until best_q has caught up.
module plic_target_arbiter import plic_pkg::*; #(
  parameter int N_SRC  = PLIC_N_SRC,
  parameter int PRIO_W = PLIC_PRIO_W
) (
  input  logic                 clock,
  input  logic                 reset_n,
  plic_target_arbiter_if.slave bus
);
  localparam int ID_W = id_w(N_SRC);

  logic [N_SRC-1:0]             r_pend;
  logic [N_SRC-1:0]             r_en;
  logic [N_SRC-1:0]             r_cpl;
  logic [N_SRC-1:0][PRIO_W-1:0] r_prio;
  logic [PRIO_W-1:0]            r_thr;

  logic [N_SRC-1:0] w_elig;
  logic [N_SRC-1:0] w_set;
  logic [N_SRC-1:0] w_clr;
  plic_best_t       w_best;
  plic_best_t       w_sel;
  logic             w_blk;
  logic [ID_W-1:0]  w_claim_id;
  logic             w_claim_fire;

  // A source competes only if it is pending, enabled and has a non-zero priority.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < N_SRC; i++)
      w_elig[i] = r_pend[i] & r_en[i] & (r_prio[i] != '0);
  end

  plic_prio_tree #(.N_SRC(N_SRC), .PRIO_W(PRIO_W)) u_tree (
    .i_elig (w_elig),
    .i_prio (r_prio),
    .o_best (w_best)
  );

`ifdef PLIC_ARB_PIPE_EN
  plic_best_t r_best_q;
  logic       r_stale;

  // best_q refreshes every cycle. Any event that can change the winner marks
  // it stale for one cycle, so a claim never acts on an out-of-date ID.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_best_q <= '0;
      r_stale  <= 1'b0;
    end else begin
      r_best_q <= w_best;
      r_stale  <= w_claim_fire | bus.prio_wen | bus.en_wen | bus.thr_wen | (|w_set);
    end
  end

  assign w_sel = r_best_q;
  assign w_blk = r_stale;
`else
  assign w_sel = w_best;
  assign w_blk = 1'b0;
`endif

  // Threshold gates eip only. claim_id still reports the winner.
  assign w_claim_id   = (w_sel.valid && !w_blk) ? w_sel.id : ID_W'(NO_IRQ_ID);
  assign w_claim_fire = bus.claim_req & (w_claim_id != ID_W'(NO_IRQ_ID));

  // Accept a request only while the source is not pending. A claim clears one bit.
  always_comb begin
    w_set = bus.gw_valid & ~r_pend;
    w_clr = '0;
    for (int i = 0; i < N_SRC; i++)
      w_clr[i] = w_claim_fire & (w_claim_id == ID_W'(i + 1));
  end

  // Pending bits: set by accepted requests and cleared by a successful claim.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_pend <= '0;
    else          r_pend <= (r_pend & ~w_clr) | w_set;
  end

  // Config registers. Priority writes to ID 0 or beyond N_SRC match no slot.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_prio <= '0;
      r_en   <= '0;
      r_thr  <= '0;
    end else begin
      for (int i = 0; i < N_SRC; i++)
        if (bus.prio_wen && (bus.prio_idx == ID_W'(i + 1))) r_prio[i] <= bus.prio_wdata;
      if (bus.en_wen)  r_en  <= bus.en_wdata;
      if (bus.thr_wen) r_thr <= bus.thr_wdata;
    end
  end

  // One-cycle completion pulse to the gateway. Out-of-range IDs decode to nothing.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_cpl <= '0;
    else
      for (int i = 0; i < N_SRC; i++)
        r_cpl[i] <= bus.complete_valid && (bus.complete_id == ID_W'(i + 1));
  end

  assign bus.gw_ready    = ~r_pend;
  assign bus.gw_complete = r_cpl;
  assign bus.claim_id    = w_claim_id;
  assign bus.eip         = w_sel.valid && (w_sel.prio > r_thr);
  assign bus.pending_o   = r_pend;
endmodule

// File: tb/tb_plic_target_arbiter.sv
// Self-checking bench for plic_target_arbiter.
// A behavioural model keeps per-ID arrays and picks the winner by a linear
// scan. Directed cases are followed by a randomized run with occasional
// resets in the middle of operation.
module tb_plic_target_arbiter;
  localparam int N  = 31;
  localparam int PW = 3;
  localparam int IW = 5;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  plic_target_arbiter_if #(.N_SRC(N), .PRIO_W(PW)) bus ();
  plic_target_arbiter #(.N_SRC(N), .PRIO_W(PW)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [N-1:0] gv;
    bit cr; bit cv; int cid;
    bit pw; int pidx; int pdata;
    bit ew; logic [N-1:0] ed;
    bit tw; int td;
  } stim_t;

  // model state, indexed by source ID
  bit m_pend [1:N];
  bit m_en   [1:N];
  bit m_cpl  [1:N];
  int m_prio [1:N];
  int m_thr;
  int m_q_id, m_q_prio;
  bit m_stale;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int arb_id();
    int b = 0;
    for (int id = 1; id <= N; id++)
      if (m_pend[id] && m_en[id] && m_prio[id] != 0 && (b == 0 || m_prio[id] > m_prio[b])) b = id;
    return b;
  endfunction

  function automatic logic [N-1:0] pend_vec();
    logic [N-1:0] v;
    for (int id = 1; id <= N; id++) v[id-1] = m_pend[id];
    return v;
  endfunction

  function automatic logic [N-1:0] cpl_vec();
    logic [N-1:0] v;
    for (int id = 1; id <= N; id++) v[id-1] = m_cpl[id];
    return v;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.gv = '0; s.cr = 0; s.cv = 0; s.cid = 0; s.pw = 0; s.pidx = 0; s.pdata = 0;
    s.ew = 0; s.ed = '0; s.tw = 0; s.td = 0;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    bus.gw_valid       = s.gv;
    bus.claim_req      = s.cr;
    bus.complete_valid = s.cv;
    bus.complete_id    = IW'(s.cid);
    bus.prio_wen       = s.pw;
    bus.prio_idx       = IW'(s.pidx);
    bus.prio_wdata     = PW'(s.pdata);
    bus.en_wen         = s.ew;
    bus.en_wdata       = s.ed;
    bus.thr_wen        = s.tw;
    bus.thr_wdata      = PW'(s.td);
  endtask

  task automatic model_clear();
    for (int id = 1; id <= N; id++) begin
      m_pend[id] = 0; m_en[id] = 0; m_cpl[id] = 0; m_prio[id] = 0;
    end
    m_thr = 0; m_q_id = 0; m_q_prio = 0; m_stale = 0;
  endtask

  // Check outputs against the model, apply one cycle of stimulus, then advance the model.
  task automatic step(input stim_t s);
    int a_id, a_pr, sel_id, sel_pr, exp_cl, claimed;
    bit any_set;
    logic [N-1:0] pv, rdy;
    a_id = arb_id();
    a_pr = (a_id != 0) ? m_prio[a_id] : 0;
`ifdef PLIC_ARB_PIPE_EN
    sel_id = m_q_id; sel_pr = m_q_prio; exp_cl = m_stale ? 0 : sel_id;
`else
    sel_id = a_id;   sel_pr = a_pr;     exp_cl = sel_id;
`endif
    pv  = pend_vec();
    rdy = ~pv;
    chk("claim_id", bus.claim_id, exp_cl);
    chk("eip", bus.eip, (sel_id != 0 && sel_pr > m_thr));
    chk("gw_ready", bus.gw_ready, rdy);
    chk("pending", bus.pending_o, pv);
    chk("gw_complete", bus.gw_complete, cpl_vec());
    drive(s);
    @(posedge clock);
    claimed = s.cr ? exp_cl : 0;
    any_set = 0;
    for (int id = 1; id <= N; id++) begin
      if (s.gv[id-1] && !m_pend[id]) begin m_pend[id] = 1; any_set = 1; end
      else if (id == claimed) m_pend[id] = 0;
      m_cpl[id] = s.cv && (s.cid == id);
      if (s.ew) m_en[id] = s.ed[id-1];
    end
    if (s.pw && s.pidx >= 1 && s.pidx <= N) m_prio[s.pidx] = s.pdata;
    if (s.tw) m_thr = s.td;
    m_q_id = a_id; m_q_prio = a_pr;
    m_stale = (claimed != 0) || s.pw || s.ew || s.tw || any_set;
    @(negedge clock);
  endtask

  task automatic do_reset();
    logic [N-1:0] ones;
    ones = '1;
    reset_n = 1'b0;
    #1;
    chk("rst_pending", bus.pending_o, 0);
    chk("rst_eip", bus.eip, 0);
    chk("rst_claim_id", bus.claim_id, 0);
    chk("rst_gw_ready", bus.gw_ready, ones);
    chk("rst_gw_complete", bus.gw_complete, 0);
    model_clear();
    drive(idle());
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    stim_t s;
    int c1, c2, c3;
    drive(idle());
    model_clear();
    do_reset();
    step(idle());

    // 1: request on ID 5 with priority 0 -> pending, no eip
    s = idle(); s.gv[4] = 1; step(s);
`ifndef PLIC_ARB_PIPE_EN
    chk("t1_pend5", bus.pending_o[4], 1);
    chk("t1_eip", bus.eip, 0);
`endif

    // 2: prio3=2, prio7=5, thr=1, all enabled, requests on 3 and 7
    s = idle(); s.pw = 1; s.pidx = 3; s.pdata = 2; step(s);
    s = idle(); s.pw = 1; s.pidx = 7; s.pdata = 5; step(s);
    s = idle(); s.ew = 1; s.ed = '1; s.tw = 1; s.td = 1; step(s);
    s = idle(); s.gv[2] = 1; s.gv[6] = 1; step(s);
`ifndef PLIC_ARB_PIPE_EN
    chk("t2_eip", bus.eip, 1);
    chk("t2_claim7", bus.claim_id, 7);
    s = idle(); s.cr = 1; step(s);
    chk("t2_pend7_clr", bus.pending_o[6], 0);
    chk("t2_claim3", bus.claim_id, 3);
`endif

    // 3: tie between IDs 2 and 9 at priority 4, then threshold 4 masks eip
    s = idle(); s.pw = 1; s.pidx = 2; s.pdata = 4; step(s);
    s = idle(); s.pw = 1; s.pidx = 9; s.pdata = 4; step(s);
    s = idle(); s.gv[1] = 1; s.gv[8] = 1; step(s);
`ifndef PLIC_ARB_PIPE_EN
    chk("t3_tie", bus.claim_id, 2);
    chk("t3_eip", bus.eip, 1);
`endif
    s = idle(); s.tw = 1; s.td = 4; step(s);
`ifndef PLIC_ARB_PIPE_EN
    chk("t3_thr_eip", bus.eip, 0);
    chk("t3_thr_claim", bus.claim_id, 2);
`endif

    // 4: completion pulses, boundary IDs, ignored priority write to ID 0
    s = idle(); s.cv = 1; s.cid = 7; step(s);
    chk("t4_cpl7", bus.gw_complete, 64'h40);
    step(idle());
    chk("t4_cpl_gone", bus.gw_complete, 0);
    s = idle(); s.cv = 1; s.cid = 0; step(s);
    chk("t4_cpl_id0", bus.gw_complete, 0);
    s = idle(); s.cv = 1; s.cid = 31; step(s);
    chk("t4_cpl31", bus.gw_complete, 64'h4000_0000);
    s = idle(); s.pw = 1; s.pidx = 0; s.pdata = 7; step(s);

    // 5: held request on a pending source, then reset during a claim
    s = idle(); s.gv[4] = 1; step(s); step(s); step(s);
    chk("t5_pend5_held", bus.pending_o[4], 1);
    bus.claim_req = 1'b1;
    #2;
    do_reset();

`ifdef PLIC_ARB_PIPE_EN
    // 6: back-to-back claims see the stale window
    s = idle(); s.pw = 1; s.pidx = 3; s.pdata = 2; step(s);
    s = idle(); s.pw = 1; s.pidx = 7; s.pdata = 5; step(s);
    s = idle(); s.ew = 1; s.ed = '1; step(s);
    s = idle(); s.gv[2] = 1; s.gv[6] = 1; step(s);
    step(idle()); step(idle());
    s = idle(); s.cr = 1;
    c1 = int'(bus.claim_id); step(s);
    c2 = int'(bus.claim_id); step(s);
    c3 = int'(bus.claim_id); step(s);
    chk("t6_first", c1, 7);
    chk("t6_stale", c2, 0);
    chk("t6_third", c3, 3);
`else
    c1 = 0; c2 = 0; c3 = 0;
`endif

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      s = idle();
      if ($urandom_range(0, 2) == 0) s.gv = N'($urandom) & N'($urandom);
      s.cr    = ($urandom_range(0, 2) == 0);
      s.cv    = ($urandom_range(0, 3) == 0);
      s.cid   = $urandom_range(0, 31);
      s.pw    = ($urandom_range(0, 3) == 0);
      s.pidx  = $urandom_range(0, 31);
      s.pdata = $urandom_range(0, 7);
      s.ew    = ($urandom_range(0, 15) == 0);
      s.ed    = N'($urandom) | N'($urandom);
      s.tw    = ($urandom_range(0, 15) == 0);
      s.td    = $urandom_range(0, 4);
      step(s);
      if ($urandom_range(0, 299) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
